seg_scan: RTL
=============

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter CLK_DIV, default 1000, clk cycles per digit slot; legal range CLK_DIV >= BLANK_CYC+1.
REQ-002 Parameter BLANK_CYC, default 8, anti-ghost blanking cycles at the start of each slot; legal range >= 1.
REQ-003 Parameter BLINK_FRAMES, default 64, frames per blink half-period (used only with SEG_SCAN_BLINK_EN).
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 digits  input  32  eight 4-bit codes; digit i at [4i+3:4i].
REQ-007 dp  input  8  decimal point per digit, 1 = lit.
REQ-008 blink  input  8  per-digit blink request, 1 = blink; ignored when the macro is absent.
REQ-009 leg  output  8  digit select, one-hot active-low, bit i = digit i.
REQ-010 dis  output  8  segment data, active-high, [6:0] = segments g..a (a = bit 0), [7] = dp.
REQ-011 frame_start  output  1  one-cycle pulse at the start of digit 0's slot.

Function
REQ-012 Slot counter cnt SHALL count 0..CLK_DIV-1 and wrap to 0; digit index idx SHALL advance on each wrap, 7 wrapping to 0.
REQ-013 When cnt = 0, the block SHALL snapshot digits[idx], dp[idx] and blink[idx] into slot registers; input changes mid-slot SHALL NOT affect the current slot.
REQ-014 Phase BLANK (cnt < BLANK_CYC): leg = 8'hFF, dis = 8'h00.
REQ-015 Phase SHOW (cnt >= BLANK_CYC): leg = ~(1 << idx), dis = {dp_snap, seg(code_snap)}.
REQ-016 seg(): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, 14 = 40 (minus), 10-13 and 15 = 00 (blank).
REQ-017 leg, dis and frame_start SHALL be registered, reflecting the cnt/idx value of the previous cycle (one-cycle latency).
REQ-018 frame_start SHALL be 1 for exactly one cycle per 8*CLK_DIV cycles, in the cycle after cnt = 0 with idx = 0.
REQ-019 At most one leg bit SHALL be low in any cycle; never two digits enabled, including across slot boundaries.
REQ-020 A blank code (dis = 00 in SHOW) SHALL still drive leg active for that digit.

Reset
REQ-021 While rst_n = 0 at a clock edge: cnt = 0, idx = 0, slot registers = 0, leg = 8'hFF, dis = 8'h00, frame_start = 0, blink state cleared.
REQ-022 Reset asserted mid-slot SHALL take effect at the next edge with no partial digit shown; scanning restarts at digit 0, BLANK phase.

Configuration
REQ-023 Macro SEG_SCAN_BLINK_EN defined: a frame counter SHALL toggle blink phase every BLINK_FRAMES frames (phase 0 after reset); in SHOW with phase 1 and blink_snap = 1, dis SHALL be 8'h00 while leg stays per REQ-015.
REQ-024 Macro absent: no frame counter or phase register SHALL be built, blink input SHALL be unused, output behaviour identical to phase always 0.

Structure
REQ-025 Shared package seg_pkg SHALL hold NUM_DIGITS = 8, the segment pattern constants of REQ-016 and the blank/minus code values 15/14.
REQ-026 Combinational decoder SHALL be a sub-module seg_decode (4-bit code in, 7-bit pattern out); scan, blanking, snapshot and blink logic stay in seg_scan.
REQ-027 seg_scan output pair (leg, dis) SHALL connect unchanged to the mode-selection stage's leg/dis inputs.

Verification (CLK_DIV = 10, BLANK_CYC = 2, BLINK_FRAMES = 2)
REQ-028 Release rst_n, digits = 32'h76543210 -> leg = FF, dis = 00 for cycles 0-2; cycle 3 leg = FE, dis = 3F; cycle 13 leg = FD, dis = 06 after blanking cycles 11-12.
REQ-029 Run 200 cycles -> frame_start pulses exactly at cycles 1, 81, 161; leg never has two zero bits.
REQ-030 Change digits[3:0] from 1 to 8 at cnt = 5 of digit 0 slot -> dis stays 06 until slot end; next frame shows 7F.
REQ-031 digits = 32'hFFFFFFEE, dp = 8'h01 -> digit 0 dis = C0, digit 1 dis = 40, digits 2-7 dis = 00 with leg still cycling.
REQ-032 Assert rst_n = 0 at cnt = 6 of digit 4 -> next cycle leg = FF, dis = 00; after release digit 0 shows at cycle 3.
REQ-033 With SEG_SCAN_BLINK_EN, blink = 8'h01 -> digit 0 dis = segments in frames 0-1, 00 in frames 2-3, repeating; other digits unaffected; without macro digit 0 never blanks.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: digit count, special codes
// and the segment patterns (bit 0 = segment a).
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [3:0] CODE_MINUS = 4'd14;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } slot_phase_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit code to seven-segment pattern decoder.
// Codes 10-13 and 15 render blank; 14 renders a minus sign.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:       seg_o = SEG_0;
            4'd1:       seg_o = SEG_1;
            4'd2:       seg_o = SEG_2;
            4'd3:       seg_o = SEG_3;
            4'd4:       seg_o = SEG_4;
            4'd5:       seg_o = SEG_5;
            4'd6:       seg_o = SEG_6;
            4'd7:       seg_o = SEG_7;
            4'd8:       seg_o = SEG_8;
            4'd9:       seg_o = SEG_9;
            CODE_MINUS: seg_o = SEG_MINUS;
            default:    seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed LED scanner with per-slot blanking and input snapshot.
// Optional digit blinking is built only when SEG_SCAN_BLINK_EN is defined.
module seg_scan
    import seg_pkg::*;
#(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYC    = 8,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digits,
    input  logic [7:0]  dp,
    input  logic [7:0]  blink,
    output logic [7:0]  leg,
    output logic [7:0]  dis,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       code_q;
    logic             dp_snap_q;
    logic [7:0]       leg_q, leg_d;
    logic [7:0]       dis_q, dis_d;
    logic             fs_q, fs_d;
    logic [6:0]       seg_pat;
    logic             blink_hide;
    slot_phase_e      phase;

    seg_decode u_decode (
        .code_i (code_q),
        .seg_o  (seg_pat)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frm_q;
    logic             blink_ph_q;
    logic             blink_snap_q;

    // Frame count advances as digit 7's slot wraps back to digit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_q        <= '0;
            blink_ph_q   <= 1'b0;
            blink_snap_q <= 1'b0;
        end else begin
            if (cnt_q == '0) begin
                blink_snap_q <= blink[idx_q];
            end
            if (cnt_q == CNT_MAX && idx_q == 3'd7) begin
                if (frm_q == FRM_MAX) begin
                    frm_q      <= '0;
                    blink_ph_q <= ~blink_ph_q;
                end else begin
                    frm_q <= frm_q + 1'b1;
                end
            end
        end
    end

    assign blink_hide = blink_ph_q & blink_snap_q;
`else
    logic unused_blink;
    assign unused_blink = ^blink;
    assign blink_hide   = 1'b0;
`endif

    assign phase = (cnt_q >= BLANK_END) ? PH_SHOW : PH_BLANK;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Outputs are computed from the current cnt/idx and registered, so the
    // digit enable always drops during the blank lead-in of the next slot.
    always_comb begin
        leg_d = 8'hFF;
        dis_d = 8'h00;
        fs_d  = (cnt_q == '0) && (idx_q == 3'd0);
        if (phase == PH_SHOW) begin
            leg_d = ~(8'h01 << idx_q);
            dis_d = blink_hide ? 8'h00 : {dp_snap_q, seg_pat};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            code_q    <= '0;
            dp_snap_q <= 1'b0;
            leg_q     <= 8'hFF;
            dis_q     <= 8'h00;
            fs_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (cnt_q == '0) begin
                code_q    <= digits[{idx_q, 2'b00} +: 4];
                dp_snap_q <= dp[idx_q];
            end
            leg_q <= leg_d;
            dis_q <= dis_d;
            fs_q  <= fs_d;
        end
    end

    assign leg         = leg_q;
    assign dis         = dis_q;
    assign frame_start = fs_q;

endmodule
